// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the command initiator: bus widths, FSM
// state encoding and the registered command record.
package wb_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic [WB_SW-1:0] sel;
  } wb_cmd_t;

  localparam wb_cmd_t WB_CMD_RESET = '{we: 1'b0, adr: '0, dat: '0, sel: '0};

  // Read data only travels back for reads; writes report zero.
  function automatic logic [WB_DW-1:0] wb_rsp_data(input logic we,
                                                   input logic [WB_DW-1:0] bus_dat);
    return we ? '0 : bus_dat;
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Clear/enable cycle counter whose terminal count flags the last permitted
// cycle of a bus transfer.
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic master: one bus cycle per accepted command, response
// carries read data or a timeout error.
module wb_cmd_initiator
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [WB_AW-1:0] cmd_adr,
  input  logic [WB_DW-1:0] cmd_dat,
  input  logic [WB_SW-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WB_DW-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  output logic [WB_SW-1:0] wbm_sel_o,
  input  logic             wbm_ack_i,
  input  logic [WB_DW-1:0] wbm_dat_i,
  output logic [1:0]       dbg_state_o
);

  // Both ports are valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid never depends on ready.

  wb_state_e        state_q, state_d;
  wb_cmd_t          cmd_q, cmd_d;
  logic             cyc_q, cyc_d;
  logic [WB_DW-1:0] rsp_dat_q, rsp_dat_d;
  logic             rsp_err_q, rsp_err_d;
  logic             ctr_clr;
  logic             ctr_en;
  logic             ctr_tc;

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk  (wb_clk_i),
    .rst_n(wb_rst_ni),
    .clr  (ctr_clr),
    .en   (ctr_en),
    .tc   (ctr_tc)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cyc_d     = cyc_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d   = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
          cyc_d   = 1'b1;
          ctr_clr = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        ctr_en = 1'b1;
        // Ack is checked first so a late ack on the final cycle still succeeds.
        if (wbm_ack_i) begin
          cyc_d     = 1'b0;
          rsp_dat_d = wb_rsp_data(cmd_q.we, wbm_dat_i);
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end else if (ctr_tc) begin
          cyc_d     = 1'b0;
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      cmd_q     <= WB_CMD_RESET;
      cyc_q     <= 1'b0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cyc_q     <= cyc_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_dat     = rsp_dat_q;
  assign rsp_err     = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = cmd_q.we;
  assign wbm_adr_o   = cmd_q.adr;
  assign wbm_dat_o   = cmd_q.dat;
  assign wbm_sel_o   = cmd_q.sel;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Bench for wb_cmd_initiator with an 8-cycle timeout and a wait-state slave
// model driven from the command tasks.
module tb_wb_cmd_initiator;
  import wb_pkg::*;

  localparam int T = 8;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic [1:0]  dbg_state_o;

  int applied    = 0;
  int miscompares = 0;
  logic [32:0] exp_q[$];

  wb_cmd_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_adr    (cmd_adr),
    .cmd_dat    (cmd_dat),
    .cmd_sel    (cmd_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dat    (rsp_dat),
    .rsp_err    (rsp_err),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_dat_i  (wbm_dat_i),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One command end to end. ack_wait: bus cycles before ack (<0 = never).
  task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_wait, input logic [31:0] rd,
                        input int bp, input logic hold_next, input logic [31:0] nxt_adr);
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_len;
    int          n;
    logic [32:0] exp;
    logic [32:0] held;
    exp_err = (ack_wait < 0) || (ack_wait >= T);
    exp_dat = (exp_err || we) ? 32'h0 : rd;
    exp_len = exp_err ? T : ack_wait + 1;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    applied++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready);
    end
    exp_q.push_back({exp_err, exp_dat});
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (wbm_cyc_o === 1'b1 && n < 100) begin
      applied++;
      if ({wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== {1'b1, we, adr, dat, sel}) begin
        miscompares++;
        $display("FAIL bus_fields: got stb=%b we=%b adr=%h dat=%h sel=%h expected stb=1 we=%b adr=%h dat=%h sel=%h",
                 wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, we, adr, dat, sel);
      end
      wbm_ack_i = (n == ack_wait);
      wbm_dat_i = wbm_ack_i ? rd : $urandom;
      @(negedge clk);
      n++;
    end
    wbm_ack_i = 1'b0;
    applied++;
    if (n != exp_len) begin
      miscompares++;
      $display("FAIL cyc_len: got %0d cycles expected %0d", n, exp_len);
    end
    applied++;
    if (rsp_valid !== 1'b1 || wbm_stb_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rsp_valid: got valid=%b stb=%b expected valid=1 stb=0", rsp_valid, wbm_stb_o);
    end
    held = {rsp_err, rsp_dat};
    if (hold_next) begin
      cmd_valid = 1'b1;
      cmd_adr   = nxt_adr;
    end
    for (int i = 0; i < bp; i++) begin
      wbm_ack_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      applied++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0 || {rsp_err, rsp_dat} !== held) begin
        miscompares++;
        $display("FAIL backpressure: got valid=%b ready=%b cyc=%b rsp=%h expected valid=1 ready=0 cyc=0 rsp=%h",
                 rsp_valid, cmd_ready, wbm_cyc_o, {rsp_err, rsp_dat}, held);
      end
    end
    wbm_ack_i = 1'b0;
    rsp_ready = 1'b1;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
    applied++;
    if ({rsp_err, rsp_dat} !== exp) begin
      miscompares++;
      $display("FAIL rsp_data: got err=%b dat=%h expected err=%b dat=%h",
               rsp_err, rsp_dat, exp[32], exp[31:0]);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    applied++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rsp_done: got valid=%b ready=%b cyc=%b expected 0 1 0", rsp_valid, cmd_ready, wbm_cyc_o);
    end
  endtask

  task automatic check_reset_values(input string tag);
    applied++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_valid, rsp_dat, rsp_err, cmd_ready, dbg_state_o}
        !== {3'b000, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1, 2'(IDLE)}) begin
      miscompares++;
      $display("FAIL %s: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h rv=%b rd=%h re=%b cr=%b st=%0d expected all 0, cmd_ready=1",
               tag, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
               rsp_valid, rsp_dat, rsp_err, cmd_ready, dbg_state_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_values");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("after_release");
  endtask

  task automatic test_write();
    do_cmd(1'b1, 32'h3000_0004, 32'hCAFE_F00D, 4'hF, 1, 32'h0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_read();
    do_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF, 4, 32'h1234_5678, 0, 1'b0, 32'h0);
  endtask

  task automatic test_timeout();
    do_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, -1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    do_cmd(1'b0, 32'h3000_0014, 32'h0, 4'h3, T - 1, 32'h0BAD_F00D, 0, 1'b0, 32'h0);
    do_cmd(1'b1, 32'h3000_0018, 32'h5555_AAAA, 4'h1, -1, 32'h0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_backpressure();
    do_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, 2, 32'hA5A5_5A5A, 10, 1'b1, 32'h3000_0024);
    do_cmd(1'b1, 32'h3000_0024, 32'h7777_8888, 4'hC, 0, 32'h0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      do_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 9)), $urandom, int'($urandom_range(0, 2)), 1'b0, 32'h0);
    end
  endtask

  task automatic test_reset_mid_bus();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0040; cmd_dat = 32'h1111_2222; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    applied++;
    if (wbm_cyc_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_bus_cyc: got %b expected 1", wbm_cyc_o);
    end
    #2 rst_n = 1'b0;
    #1;
    applied++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
      miscompares++;
      $display("FAIL async_drop: got cyc=%b stb=%b expected 0 0", wbm_cyc_o, wbm_stb_o);
    end
    check_reset_values("mid_bus_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wbm_ack_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      applied++;
      if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL post_reset_idle: got rv=%b cyc=%b cr=%b expected 0 0 1", rsp_valid, wbm_cyc_o, cmd_ready);
      end
    end
    wbm_ack_i = 1'b0;
  endtask

  task automatic test_spurious_ack();
    for (int i = 0; i < 5; i++) begin
      wbm_ack_i = (i % 2 == 0);
      wbm_dat_i = $urandom;
      @(negedge clk);
      applied++;
      if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b1 || dbg_state_o !== 2'(IDLE)) begin
        miscompares++;
        $display("FAIL spurious_ack: got rv=%b cyc=%b cr=%b st=%0d expected 0 0 1 0",
                 rsp_valid, wbm_cyc_o, cmd_ready, dbg_state_o);
      end
    end
    wbm_ack_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_backpressure();
    test_spurious_ack();
    test_back_to_back();
    test_reset_mid_bus();
    test_read();
    applied++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
